// File: rtl/modport_mem_if.sv
// Storage bus between a driver (master) and the modport_mem array (slave).
interface mem_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output rd_en, wr_en, addr, wdata,
    input  rdata
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/modport_mem.sv
// Register-based DEPTH x DATA_W memory with registered read data.
// Define MODPORT_MEM_WR_FWD_EN to forward wdata on a same-address read/write.
module modport_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic  clk,
  input  logic  reset,
  mem_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read path: hold on idle; the stored word is read before this edge's write lands.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd_en) begin
`ifdef MODPORT_MEM_WR_FWD_EN
      if (bus.wr_en) begin
        rdata_d = bus.wdata;
      end else begin
        rdata_d = mem_q[bus.addr];
      end
`else
      rdata_d = mem_q[bus.addr];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      mem_q[bus.addr] <= bus.wdata;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_modport_mem.sv
// Scoreboard bench for modport_mem: expected rdata queued per driven cycle, checked before the next edge.
module tb_modport_mem;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
`ifdef MODPORT_MEM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;

  mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  modport_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q [$];
  string             tag_q [$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] rd_m;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle (called at posedge+1) and queues the rdata expected after that edge.
  task automatic cyc(input logic rst, input logic rd, input logic wr,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input string tag);
    logic [DATA_W-1:0] old;
    reset     = rst;
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.addr  = a;
    bus.wdata = d;
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
      rd_m = '0;
    end else begin
      old = mem_m[a];
      if (rd) rd_m = (FWD && wr) ? d : old;
      if (wr) mem_m[a] = d;
    end
    exp_q.push_back(rd_m);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample rdata one time unit before the following edge.
  int                pend;
  logic [DATA_W-1:0] exp_v;
  string             tag_v;
  always begin
    @(posedge clk);
    pend = exp_q.size();
    #9;
    if (pend > 0) begin
      exp_v = exp_q.pop_front();
      tag_v = tag_q.pop_front();
      check(tag_v, bus.rdata, exp_v);
    end
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] pat;
    reset     = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    rd_m      = '0;
    @(posedge clk);
    #1;

    cyc(1'b1, 1'b0, 1'b0, '0, '0, "reset0");
    cyc(1'b1, 1'b1, 1'b1, 4'd1, 16'h5555, "reset1");
    for (int i = 0; i < int'(DEPTH); i++)
      cyc(1'b0, 1'b1, 1'b0, ADDR_W'(i), 16'hDEAD, "rd_after_reset");

    cyc(1'b0, 1'b0, 1'b1, 4'd3, 16'hA5A5, "wr3");
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 16'h0000, "rd3");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, ADDR_W'(i), 16'h1111, "rd3_hold");

    for (int i = 0; i < int'(DEPTH); i++) begin
      a   = ADDR_W'(i);
      pat = {a, a, a, a};
      cyc(1'b0, 1'b0, 1'b1, a, pat, "wr_pat");
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--)
      cyc(1'b0, 1'b1, 1'b0, ADDR_W'(i), 16'h0, "rd_pat_rev");

    cyc(1'b0, 1'b0, 1'b1, 4'd5, 16'h1234, "wr5");
    cyc(1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF, "rw_same5");
    cyc(1'b0, 1'b1, 1'b0, 4'd5, 16'h0, "rd5_after_rw");
    cyc(1'b0, 1'b1, 1'b1, 4'd6, 16'hCAFE, "rw_same6");

    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)),
          DATA_W'($urandom), "idle_hold");
    for (int i = 0; i < int'(DEPTH); i++)
      cyc(1'b0, 1'b1, 1'b0, ADDR_W'(i), 16'h0, "rd_after_idle");

    cyc(1'b0, 1'b0, 1'b1, 4'd9, 16'hFFFF, "wr9");
    cyc(1'b0, 1'b1, 1'b0, 4'd9, 16'h0, "rd9_ffff");
    cyc(1'b1, 1'b0, 1'b1, 4'd9, 16'h0F0F, "reset_drop_wr");
    cyc(1'b0, 1'b1, 1'b0, 4'd9, 16'h0, "rd9_after_reset");
    cyc(1'b0, 1'b1, 1'b0, 4'd5, 16'h0, "rd5_after_reset");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, "final_idle");

    #20;
    check("sb_empty", DATA_W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
